// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: FSM state encoding and sizing helper shared by serial_adder.
package serial_adder_pkg;

    localparam int unsigned STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    // Counter width for n chunks, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/serial_adder_full_adder.sv
// full_adder_cell: one-bit full adder, chained BPC-deep inside serial_adder.
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// serial_adder: multi-cycle WIDTH-bit adder, BPC bits per cycle, valid/ready on both sides.
// Define SERIAL_ADDER_SUB_EN to add a 'sub' input selecting a - b.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned BPC   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned      NCHUNK = WIDTH / BPC;
    localparam int unsigned      CNT_W  = cnt_width(NCHUNK);
    localparam logic [CNT_W-1:0] LAST   = CNT_W'(NCHUNK - 1);

    if (WIDTH < 1 || BPC < 1 || (WIDTH % BPC) != 0) begin : g_bad_cfg
        $error("serial_adder: BPC=%0d must divide WIDTH=%0d", BPC, WIDTH);
    end

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, b_q, sum_q;
    logic [CNT_W-1:0] count_q;
    logic             carry_q;
    logic             rdy_en_q;
    logic [BPC-1:0]   chunk_s;
    logic [BPC:0]     chain;
    logic             accept;

    assign in_ready  = rdy_en_q && (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign cout      = carry_q;
    assign accept    = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = RUN;
            RUN:     if (count_q == LAST) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign chain[0] = carry_q;
    for (genvar i = 0; i < BPC; i++) begin : g_fa
        full_adder_cell u_fa (
            .a  (a_q[i]),
            .b  (b_q[i]),
            .ci (chain[i]),
            .s  (chunk_s[i]),
            .co (chain[i+1])
        );
    end

    // Operands shift down so chunk[count] is always in the low BPC bits; sum fills
    // from the top, so after NCHUNK steps every chunk sits at its own position.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            sum_q    <= '0;
            count_q  <= '0;
            carry_q  <= 1'b0;
            rdy_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rdy_en_q <= 1'b1;
            if (accept) begin
                a_q     <= a;
`ifdef SERIAL_ADDER_SUB_EN
                b_q     <= sub ? ~b : b;
                carry_q <= sub | cin;
`else
                b_q     <= b;
                carry_q <= cin;
`endif
                count_q <= '0;
            end else if (state_q == RUN) begin
                a_q     <= a_q >> BPC;
                b_q     <= b_q >> BPC;
                sum_q   <= WIDTH'({chunk_s, sum_q} >> BPC);
                carry_q <= chain[BPC];
                count_q <= count_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: vector table, corner sequences and scoreboarded random traffic
// against serial_adder instances with BPC = 1, 2, 4, 8 (WIDTH = 8).
`timescale 1ns/1ps
module tb_serial_adder;

    localparam int unsigned W  = 8;
    localparam int          ND = 4;
`ifdef SERIAL_ADDER_SUB_EN
    localparam bit SUB_EN = 1'b1;
`else
    localparam bit SUB_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid_s  [ND];
    logic         in_ready_s  [ND];
    logic [W-1:0] a_s         [ND];
    logic [W-1:0] b_s         [ND];
    logic         cin_s       [ND];
    logic         sub_s       [ND];
    logic         out_valid_s [ND];
    logic         out_ready_s [ND];
    logic [W-1:0] sum_s       [ND];
    logic         cout_s      [ND];

    int total = 0;
    int bad   = 0;
    logic [W:0] sb_q[$];

    typedef struct {
        int         k;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic       ci;
        logic       s;
        logic [W-1:0] sum;
        logic       co;
        int         lat;
    } vec_t;
    vec_t vecs[$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        serial_adder #(.WIDTH(W), .BPC(1 << g)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid_s[g]),
            .in_ready  (in_ready_s[g]),
            .a         (a_s[g]),
            .b         (b_s[g]),
            .cin       (cin_s[g]),
`ifdef SERIAL_ADDER_SUB_EN
            .sub       (sub_s[g]),
`endif
            .out_valid (out_valid_s[g]),
            .out_ready (out_ready_s[g]),
            .sum       (sum_s[g]),
            .cout      (cout_s[g])
        );
    end

    function automatic logic [W:0] model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                         input logic ci, input logic s);
        if (s) return {1'b0, av} + {1'b0, ~bv} + (W+1)'(1);
        return {1'b0, av} + {1'b0, bv} + {{W{1'b0}}, ci};
    endfunction

    function automatic logic [W:0] b2(input logic x);
        return {{W{1'b0}}, x};
    endfunction

    task automatic chk(input string name, input logic [W:0] act, input logic [W:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Waits (bounded) for in_ready, presents one operand set, returns at the
    // first negedge after the accepting edge.
    task automatic start_op(input int k, input logic [W-1:0] av, input logic [W-1:0] bv,
                            input logic ci, input logic s);
        int n = 0;
        while (!in_ready_s[k] && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready_before_op", b2(in_ready_s[k]), b2(1'b1));
        a_s[k] = av; b_s[k] = bv; cin_s[k] = ci; sub_s[k] = s;
        in_valid_s[k] = 1'b1;
        sb_q.push_back(model(av, bv, ci, s));
        @(negedge clk);
        in_valid_s[k] = 1'b0;
    endtask

    task automatic wait_valid(input int k, output int lat);
        lat = 0;
        while (!out_valid_s[k] && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic pop_check(input string name, input int k);
        logic [W:0] e;
        e = (sb_q.size() > 0) ? sb_q.pop_front() : 'x;
        chk(name, {cout_s[k], sum_s[k]}, e);
    endtask

    task automatic handshake(input int k);
        out_ready_s[k] = 1'b1;
        @(negedge clk);
        out_ready_s[k] = 1'b0;
    endtask

    task automatic rnd_drive(input int k, input int n);
        for (int i = 0; i < n; i++) begin
            int tries = 0;
            bit acc   = 1'b0;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            while (!acc && tries < 200) begin
                a_s[k]   = W'($urandom);
                b_s[k]   = W'($urandom);
                cin_s[k] = 1'($urandom_range(0, 1));
                sub_s[k] = SUB_EN ? 1'($urandom_range(0, 1)) : 1'b0;
                in_valid_s[k] = 1'b1;
                if (in_ready_s[k]) begin
                    sb_q.push_back(model(a_s[k], b_s[k], cin_s[k], sub_s[k]));
                    acc = 1'b1;
                end
                @(negedge clk);
                tries++;
            end
            in_valid_s[k] = 1'b0;
            chk("rnd_accept", b2(acc), b2(1'b1));
            if (!acc) break;
        end
    endtask

    task automatic rnd_mon(input int k, input int n);
        int got = 0;
        int cyc = 0;
        while (got < n && cyc < n * 30) begin
            out_ready_s[k] = ($urandom_range(0, 3) != 0);
            chk("rnd_ready_valid_excl", b2(in_ready_s[k] & out_valid_s[k]), b2(1'b0));
            if (out_valid_s[k] && out_ready_s[k]) begin
                pop_check($sformatf("rnd_result_bpc%0d", 1 << k), k);
                got++;
            end
            @(negedge clk);
            cyc++;
        end
        out_ready_s[k] = 1'b0;
        chk("rnd_result_count", (W+1)'(got), (W+1)'(n));
    endtask

    initial begin
        int lat;
        rst_n = 1'b0;
        for (int k = 0; k < ND; k++) begin
            in_valid_s[k] = 1'b0; out_ready_s[k] = 1'b0;
            a_s[k] = '0; b_s[k] = '0; cin_s[k] = 1'b0; sub_s[k] = 1'b0;
        end

        vecs.push_back('{0, 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 8});
        vecs.push_back('{2, 8'h5A, 8'h3C, 1'b1, 1'b0, 8'h97, 1'b0, 2});
        vecs.push_back('{1, 8'h80, 8'h80, 1'b1, 1'b0, 8'h01, 1'b1, 4});
        vecs.push_back('{3, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1});
        vecs.push_back('{3, 8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1});
        vecs.push_back('{0, 8'h12, 8'h34, 1'b1, 1'b0, 8'h47, 1'b0, 8});
        vecs.push_back('{1, 8'hAA, 8'h55, 1'b0, 1'b0, 8'hFF, 1'b0, 4});
        vecs.push_back('{2, 8'hF0, 8'h0F, 1'b1, 1'b0, 8'h00, 1'b1, 2});
`ifdef SERIAL_ADDER_SUB_EN
        vecs.push_back('{0, 8'h10, 8'h20, 1'b0, 1'b1, 8'hF0, 1'b0, 8});
        vecs.push_back('{2, 8'h20, 8'h10, 1'b0, 1'b1, 8'h10, 1'b1, 2});
        vecs.push_back('{1, 8'h05, 8'h05, 1'b1, 1'b1, 8'h00, 1'b1, 4});
        vecs.push_back('{3, 8'h33, 8'h11, 1'b1, 1'b0, 8'h45, 1'b0, 1});
`endif

        #2;
        for (int k = 0; k < ND; k++) begin
            chk("rst_in_ready",  b2(in_ready_s[k]),  b2(1'b0));
            chk("rst_out_valid", b2(out_valid_s[k]), b2(1'b0));
            chk("rst_sum_cout",  {cout_s[k], sum_s[k]}, '0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("in_ready_before_first_clk", b2(in_ready_s[0]), b2(1'b0));
        @(negedge clk);
        chk("in_ready_after_first_clk", b2(in_ready_s[0]), b2(1'b1));

        for (int i = 0; i < vecs.size(); i++) begin
            vec_t v;
            v = vecs[i];
            start_op(v.k, v.a, v.b, v.ci, v.s);
            chk($sformatf("vec%0d_table_model", i), {v.co, v.sum}, sb_q[sb_q.size()-1]);
            wait_valid(v.k, lat);
            chk($sformatf("vec%0d_latency", i), (W+1)'(lat), (W+1)'(v.lat));
            pop_check($sformatf("vec%0d_result", i), v.k);
            chk($sformatf("vec%0d_in_ready_in_done", i), b2(in_ready_s[v.k]), b2(1'b0));
            handshake(v.k);
            chk($sformatf("vec%0d_in_ready_after", i), b2(in_ready_s[v.k]), b2(1'b1));
        end

        // Backpressure: result must hold through 5 stalled cycles.
        start_op(0, 8'hC3, 8'h5A, 1'b1, 1'b0);
        wait_valid(0, lat);
        chk("bp_latency", (W+1)'(lat), (W+1)'(8));
        chk("bp_result", {cout_s[0], sum_s[0]}, 9'h11E);
        repeat (5) begin
            @(negedge clk);
            chk("bp_hold", {cout_s[0], sum_s[0]}, 9'h11E);
            chk("bp_out_valid", b2(out_valid_s[0]), b2(1'b1));
            chk("bp_in_ready_low", b2(in_ready_s[0]), b2(1'b0));
        end
        pop_check("bp_scoreboard", 0);
        out_ready_s[0] = 1'b1;
        chk("bp_no_bypass", b2(in_ready_s[0]), b2(1'b0));
        @(negedge clk);
        out_ready_s[0] = 1'b0;
        chk("bp_in_ready_next", b2(in_ready_s[0]), b2(1'b1));
        chk("bp_out_valid_drop", b2(out_valid_s[0]), b2(1'b0));

        // Reset in the middle of a BPC=1 run.
        start_op(0, 8'hFF, 8'h00, 1'b0, 1'b0);
        void'(sb_q.pop_back());
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", b2(out_valid_s[0]), b2(1'b0));
        chk("midrst_sum_cout",  {cout_s[0], sum_s[0]}, '0);
        chk("midrst_in_ready",  b2(in_ready_s[0]), b2(1'b0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        start_op(0, 8'h7F, 8'h01, 1'b0, 1'b0);
        wait_valid(0, lat);
        chk("postrst_latency", (W+1)'(lat), (W+1)'(8));
        chk("postrst_result", {cout_s[0], sum_s[0]}, 9'h080);
        pop_check("postrst_scoreboard", 0);
        handshake(0);

        for (int k = 0; k < ND; k++) begin
            fork
                rnd_drive(k, 1000);
                rnd_mon(k, 1000);
            join
        end
        chk("sb_drained", (W+1)'(sb_q.size()), '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
